// File: rtl/int_ctrl.sv
// Interrupt controller: edge-detected requests, fixed lowest-index priority, vector address
// generation and return-address save/replay. Optional INTC_SYNC_EN adds a 2-flop input synchronizer.
module int_ctrl #(
  parameter int unsigned NUM_SRC       = 8,
  parameter logic [3:0]  IO_ADDR_MASK  = 4'hC,
  parameter logic [3:0]  IO_ADDR_PEND  = 4'hD,
  parameter logic [3:0]  IO_ADDR_VBASE = 4'hE,
  parameter logic [3:0]  IO_ADDR_STAT  = 4'hF,
  parameter logic [15:0] VBASE_RESET   = 16'h0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               io_interrupt,
  input  logic               io_store_retaddr,
  input  logic               io_push_int_addr,
  input  logic               io_push_retaddr,
  input  logic [3:0]         io_addr,
  input  logic               io_write,
  input  logic               io_push,
  output logic [15:0]        int_addr,
  output logic               int_addr_oe,
  inout  wire  [15:0]        d_bus
);

  typedef enum logic {StIdle, StInService} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] irq_filt, irq_prev_q, irq_rise;
  logic [NUM_SRC-1:0] active, clr_ack, clr_w1c;
  logic [15:0]        vbase_q, vbase_d;
  logic [15:0]        retaddr_q, retaddr_d;
  logic [3:0]         id_q, id_d, winner;
  logic               any_active, ack;
  logic               bus_oe;
  logic [15:0]        bus_val;

`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_filt = sync2_q;
`else
  assign irq_filt = irq_in;
`endif

  assign irq_rise   = irq_filt & ~irq_prev_q;
  assign active     = pend_q & mask_q;
  assign any_active = |active;

  always_comb begin
    winner = 4'(NUM_SRC);
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (active[i]) winner = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    ack     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (io_store_retaddr) begin
          ack     = 1'b1;
          state_d = StInService;
        end
      end
      StInService: begin
        if (io_push_retaddr) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    retaddr_d = retaddr_q;
    id_d      = id_q;
    mask_d    = mask_q;
    vbase_d   = vbase_q;
    clr_ack   = '0;
    clr_w1c   = '0;
    if (ack) begin
      retaddr_d = d_bus;
      id_d      = winner;
      // Isolate the lowest set bit; zero on a spurious ack.
      clr_ack   = active & (~active + 1'b1);
    end
    if (io_write) begin
      if (io_addr == IO_ADDR_MASK)  mask_d  = d_bus[NUM_SRC-1:0];
      if (io_addr == IO_ADDR_VBASE) vbase_d = d_bus;
      if (io_addr == IO_ADDR_PEND)  clr_w1c = d_bus[NUM_SRC-1:0];
    end
    // A fresh edge wins over both clear sources.
    pend_d = (pend_q & ~clr_ack & ~clr_w1c) | irq_rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mask_q     <= '0;
      pend_q     <= '0;
      vbase_q    <= VBASE_RESET;
      retaddr_q  <= '0;
      id_q       <= '0;
      irq_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      vbase_q    <= vbase_d;
      retaddr_q  <= retaddr_d;
      id_q       <= id_d;
      irq_prev_q <= irq_filt;
    end
  end

  assign io_interrupt = (state_q == StIdle) && any_active;
  assign int_addr     = vbase_q + {12'b0, id_q};
  assign int_addr_oe  = io_push_int_addr;

  always_comb begin
    bus_oe  = 1'b0;
    bus_val = '0;
    if (io_push_retaddr) begin
      bus_oe  = 1'b1;
      bus_val = retaddr_q;
    end else if (io_push) begin
      if (io_addr == IO_ADDR_MASK) begin
        bus_oe  = 1'b1;
        bus_val = 16'(mask_q);
      end else if (io_addr == IO_ADDR_PEND) begin
        bus_oe  = 1'b1;
        bus_val = 16'(pend_q);
      end else if (io_addr == IO_ADDR_VBASE) begin
        bus_oe  = 1'b1;
        bus_val = vbase_q;
      end else if (io_addr == IO_ADDR_STAT) begin
        bus_oe  = 1'b1;
        bus_val = {11'b0, state_q == StInService, id_q};
      end
    end
  end

  assign d_bus = bus_oe ? bus_val : 'z;

endmodule
